flb_cap_decoder: RTL and testbench
==================================

// Module: flb_cap_decoder
// PURPOSE
// - Frequency-locking-block (FLB) DCO capacitor-bank decoder. Converts an 8-bit binary cap code into
//   row/column drive for a 16x16 unit-cap matrix. Converts an 8-bit band code into a registered binary copy
//   and two 16-bit thermometer words.
// - Sits between the FLB control loop and the DCO analog cap arrays.
// - Unit cell (r,c) is ON when row_p[r] | (row_n[r] & col_on[c]); ON-cell count == s_mtrx.
// PARAMETERS
// - none; all widths are fixed: 8-bit codes, 16 rows, 16 columns.
// PORTS
// - clk            in   1   single clock; all state updates on rising edge
// - csr_flb_rst_n  in   1   asynchronous, active-low reset
// - s_mtrx         in   8   binary matrix cap code (0..255)
// - s_band         in   8   binary band code
// - row_p          out  16  row fully-on enables
// - row_n          out  16  one-hot partial (active) row select
// - col_on         out  16  column thermometer for the active row
// - col_off        out  16  bitwise complement of col_on
// - band_bin       out  8   registered s_band
// - band_thrm_hi   out  16  thermometer of s_band[7:4]
// - band_thrm_lo   out  16  thermometer of s_band[3:0]
// - dec_err        out  1   self-check flag (see CONFIGURATION)
// BEHAVIOUR
// - Split the codes: hi = s_mtrx[7:4], lo = s_mtrx[3:0]; bhi = s_band[7:4], blo = s_band[3:0].
// - Next-state, for k = 0..15:
//   - row_p[k] = (k < hi)
//   - row_n[k] = (k == hi)
//   - col_on[k] = (k < lo); col_off = ~col_on
//   - band_thrm_hi[k] = (k < bhi); band_thrm_lo[k] = (k < blo); band_bin = s_band
// - Every output is registered. Latency is one clock: an input applied before rising edge N is visible after edge N.
//   There is no handshake. Inputs are sampled on every edge.
// - Reset (async assert, released synchronously by the environment) forces the decode of code 0:
//   - row_p=0, row_n=16'h0001, col_on=0, col_off=16'hFFFF
//   - band_bin=0, band_thrm_hi=0, band_thrm_lo=0, dec_err=0
// - Boundaries:
//   - s_mtrx=0: row_n[0] only, no caps on.
//   - s_mtrx=255: row_p=16'h7FFF, row_n=16'h8000, col_on=16'h7FFF, giving 255 caps.
//   - lo=0: the active row contributes nothing. The row code is never all-ones, so there is no row wrap.
// - Reset asserted mid-operation takes effect immediately, regardless of clk. Decoding resumes on the first edge after release.
// - Invariants, checked every cycle:
//   - popcount(row_n)==1
//   - row_p below row_n is a thermometer
//   - col_on is a thermometer
//   - col_on ^ col_off == 16'hFFFF
// CONFIGURATION
// - FLB_DEC_SELFCHECK_EN defined: extra logic recomputes 16*popcount(row_p) + popcount(col_on) from the registered outputs
//   and compares it with a registered copy of s_mtrx, together with the invariants above.
//   - dec_err is set on any mismatch and stays set (sticky) until reset.
// - FLB_DEC_SELFCHECK_EN undefined: no check logic; dec_err is tied to 0.
// - Decode outputs are identical in both builds.
// TESTING
// - Reset low for 2 clocks -> row_n=16'h0001, col_off=16'hFFFF, all other outputs 0; reset high with no clock edge -> outputs unchanged.
// - s_band=8'hD5, one edge -> band_bin=8'hD5, band_thrm_hi=16'h1FFF, band_thrm_lo=16'h001F.
// - Sweep s_mtrx 0..255, one edge per value -> a reference encoder counts ON cells; count must equal s_mtrx for all 256 codes.
// - s_mtrx=8'h37 -> row_p=16'h0007, row_n=16'h0008, col_on=16'h007F, col_off=16'hFF80.
// - s_mtrx=8'hFF, then reset asserted between edges -> outputs return to reset values immediately.
// - With FLB_DEC_SELFCHECK_EN: full sweep -> dec_err stays 0. Forcing row_n to 16'h0003 -> dec_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/flb_cap_decoder.sv
// FLB DCO capacitor-bank decoder: 8-bit cap code to 16x16 row/column drive, 8-bit band code to thermometers.
// Optional registered self-check enabled by defining FLB_DEC_SELFCHECK_EN; otherwise dec_err is tied low.
module flb_cap_decoder (
  input  logic        clk,
  input  logic        csr_flb_rst_n,
  input  logic [7:0]  s_mtrx,
  input  logic [7:0]  s_band,
  output logic [15:0] row_p,
  output logic [15:0] row_n,
  output logic [15:0] col_on,
  output logic [15:0] col_off,
  output logic [7:0]  band_bin,
  output logic [15:0] band_thrm_hi,
  output logic [15:0] band_thrm_lo,
  output logic        dec_err
);

  function automatic logic [15:0] thrm16(input logic [3:0] n);
    logic [15:0] t;
    t = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      t[k] = (k < int'(n));
    end
    return t;
  endfunction

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int k = 0; k < 16; k++) begin
      c = c + {4'd0, v[k]};
    end
    return c;
  endfunction

  logic [15:0] row_p_q, row_p_d;
  logic [15:0] row_n_q, row_n_d;
  logic [15:0] col_on_q, col_on_d;
  logic [15:0] col_off_q, col_off_d;
  logic [7:0]  band_bin_q, band_bin_d;
  logic [15:0] band_hi_q, band_hi_d;
  logic [15:0] band_lo_q, band_lo_d;

  // Next-state decode of both codes
  always_comb begin
    row_p_d    = thrm16(s_mtrx[7:4]);
    row_n_d    = 16'h0001 << s_mtrx[7:4];
    col_on_d   = thrm16(s_mtrx[3:0]);
    col_off_d  = ~thrm16(s_mtrx[3:0]);
    band_bin_d = s_band;
    band_hi_d  = thrm16(s_band[7:4]);
    band_lo_d  = thrm16(s_band[3:0]);
  end

  // Output registers; reset loads the decode of code 0
  always_ff @(posedge clk or negedge csr_flb_rst_n) begin
    if (!csr_flb_rst_n) begin
      row_p_q    <= 16'h0000;
      row_n_q    <= 16'h0001;
      col_on_q   <= 16'h0000;
      col_off_q  <= 16'hFFFF;
      band_bin_q <= 8'h00;
      band_hi_q  <= 16'h0000;
      band_lo_q  <= 16'h0000;
    end else begin
      row_p_q    <= row_p_d;
      row_n_q    <= row_n_d;
      col_on_q   <= col_on_d;
      col_off_q  <= col_off_d;
      band_bin_q <= band_bin_d;
      band_hi_q  <= band_hi_d;
      band_lo_q  <= band_lo_d;
    end
  end

  assign row_p        = row_p_q;
  assign row_n        = row_n_q;
  assign col_on       = col_on_q;
  assign col_off      = col_off_q;
  assign band_bin     = band_bin_q;
  assign band_thrm_hi = band_hi_q;
  assign band_thrm_lo = band_lo_q;

`ifdef FLB_DEC_SELFCHECK_EN
  logic [7:0] mtrx_q;
  logic       err_q, err_d;
  logic [8:0] cnt_s;
  logic       mismatch_s;

  // Cap count rebuilt from the registered drive must match the code that produced it
  always_comb begin
    cnt_s      = {popcnt16(row_p_q), 4'b0000} + {4'b0000, popcnt16(col_on_q)};
    mismatch_s = (cnt_s != {1'b0, mtrx_q})
               || (popcnt16(row_n_q) != 5'd1)
               || (row_p_q != (row_n_q - 16'd1))
               || ((col_on_q & (col_on_q + 16'd1)) != 16'h0000)
               || ((col_on_q ^ col_off_q) != 16'hFFFF);
    err_d      = err_q | mismatch_s;
  end

  // Sticky error flag and code copy aligned with the decode registers
  always_ff @(posedge clk or negedge csr_flb_rst_n) begin
    if (!csr_flb_rst_n) begin
      mtrx_q <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      mtrx_q <= s_mtrx;
      err_q  <= err_d;
    end
  end

  assign dec_err = err_q;
`else
  assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_flb_cap_decoder.sv
// Table-driven, sweep and randomized checks of flb_cap_decoder against an arithmetic reference model.
module tb_flb_cap_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_mtrx, s_band;
  logic [15:0] row_p, row_n, col_on, col_off, band_thrm_hi, band_thrm_lo;
  logic [7:0]  band_bin;
  logic        dec_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flb_cap_decoder dut (
    .clk          (clk),
    .csr_flb_rst_n(rst_n),
    .s_mtrx       (s_mtrx),
    .s_band       (s_band),
    .row_p        (row_p),
    .row_n        (row_n),
    .col_on       (col_on),
    .col_off      (col_off),
    .band_bin     (band_bin),
    .band_thrm_hi (band_thrm_hi),
    .band_thrm_lo (band_thrm_lo),
    .dec_err      (dec_err)
  );

  typedef struct {
    logic [7:0]  mtrx;
    logic [7:0]  band;
    logic [15:0] rp, rn, con, bhi, blo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Number of unit cells switched on, evaluated cell by cell over the 16x16 matrix
  function automatic int on_cells();
    int cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (row_p[r] | (row_n[r] & col_on[c])) cnt++;
    return cnt;
  endfunction

  function automatic logic [15:0] ones_below(input int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row_p"},   row_p,        16'h0000);
    chk({tag, "_row_n"},   row_n,        16'h0001);
    chk({tag, "_col_on"},  col_on,       16'h0000);
    chk({tag, "_col_off"}, col_off,      16'hFFFF);
    chk({tag, "_band"},    {8'h00, band_bin}, 16'h0000);
    chk({tag, "_bhi"},     band_thrm_hi, 16'h0000);
    chk({tag, "_blo"},     band_thrm_lo, 16'h0000);
    chk({tag, "_err"},     {15'd0, dec_err}, 16'h0000);
  endtask

  task automatic chk_model(input string tag, input logic [7:0] m, input logic [7:0] b);
    int hi = int'(m) / 16;
    int lo = int'(m) % 16;
    chk({tag, "_row_p"},   row_p,        ones_below(hi));
    chk({tag, "_row_n"},   row_n,        16'(32'd1 << hi));
    chk({tag, "_col_on"},  col_on,       ones_below(lo));
    chk({tag, "_col_off"}, col_off,      ~ones_below(lo));
    chk({tag, "_band"},    {8'h00, band_bin}, {8'h00, b});
    chk({tag, "_bhi"},     band_thrm_hi, ones_below(int'(b) / 16));
    chk({tag, "_blo"},     band_thrm_lo, ones_below(int'(b) % 16));
    chk({tag, "_cells"},   16'(on_cells()), {8'h00, m});
    chk({tag, "_err"},     {15'd0, dec_err}, 16'h0000);
  endtask

  initial begin
    vecs[0] = '{8'h37, 8'hD5, 16'h0007, 16'h0008, 16'h007F, 16'h1FFF, 16'h001F};
    vecs[1] = '{8'h00, 8'h00, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{8'h10, 8'h0F, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h7FFF};
    vecs[4] = '{8'h0F, 8'hF0, 16'h0000, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h0000};
    vecs[5] = '{8'hA3, 8'h48, 16'h03FF, 16'h0400, 16'h0007, 16'h000F, 16'h00FF};

    rst_n  = 1'b0;
    s_mtrx = 8'h5A;
    s_band = 8'hC3;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    #1;
    chk_reset_vals("rel_noedge");

    for (int i = 0; i < 6; i++) begin
      s_mtrx = vecs[i].mtrx;
      s_band = vecs[i].band;
      @(negedge clk);
      chk("tab_row_p",   row_p,        vecs[i].rp);
      chk("tab_row_n",   row_n,        vecs[i].rn);
      chk("tab_col_on",  col_on,       vecs[i].con);
      chk("tab_col_off", col_off,      ~vecs[i].con);
      chk("tab_band",    {8'h00, band_bin}, {8'h00, vecs[i].band});
      chk("tab_bhi",     band_thrm_hi, vecs[i].bhi);
      chk("tab_blo",     band_thrm_lo, vecs[i].blo);
      chk("tab_cells",   16'(on_cells()), {8'h00, vecs[i].mtrx});
    end

    for (int m = 0; m < 256; m++) begin
      s_mtrx = 8'(m);
      s_band = 8'(255 - m);
      @(negedge clk);
      chk_model("sweep", 8'(m), 8'(255 - m));
    end

    for (int i = 0; i < 40; i++) begin
      s_mtrx = 8'($urandom_range(0, 255));
      s_band = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk_model("rand", s_mtrx, s_band);
    end

    s_mtrx = 8'hFF;
    s_band = 8'h99;
    @(negedge clk);
    chk("pre_rst_row_p", row_p, 16'h7FFF);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n  = 1'b1;
    s_mtrx = 8'h37;
    s_band = 8'hD5;
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    chk_model("resume", 8'h37, 8'hD5);

`ifdef FLB_DEC_SELFCHECK_EN
    force dut.row_n_q = 16'h0003;
    @(negedge clk);
    release dut.row_n_q;
    @(negedge clk);
    chk("force_err", {15'd0, dec_err}, 16'h0001);
    repeat (3) @(negedge clk);
    chk("err_sticky", {15'd0, dec_err}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", {15'd0, dec_err}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
